// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline definitions for the hazard sequencer: multi-cycle FSM states,
// EX-stage forwarding select encodings and the register index width.
package hazard_sequencer_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_sequencer_forward_unit.sv
// Forwarding select for one EX operand. The integer x0 never forwards, but
// float f0 is a real register and does.
module hazard_sequencer_forward_unit
  import hazard_sequencer_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic                 fp_op_i,
  input  logic [REG_IDX_W-1:0] rd_m_i,
  input  logic                 reg_write_m_i,
  input  logic                 fwrite_m_i,
  input  logic [REG_IDX_W-1:0] rd_w_i,
  input  logic                 reg_write_w_i,
  input  logic                 fwrite_w_i,
  output logic [1:0]           fwd_o
);

  logic hit_m_s;
  logic hit_w_s;

  assign hit_m_s = reg_write_m_i && (rd_m_i == rs_i) && (fwrite_m_i == fp_op_i) &&
                   (fwrite_m_i || (rd_m_i != {REG_IDX_W{1'b0}}));
  assign hit_w_s = reg_write_w_i && (rd_w_i == rs_i) && (fwrite_w_i == fp_op_i) &&
                   (fwrite_w_i || (rd_w_i != {REG_IDX_W{1'b0}}));

  // Younger MEM result takes priority over WB.
  always_comb begin
    fwd_o = FWD_RF;
    if (hit_m_s) begin
      fwd_o = FWD_MEM;
    end else if (hit_w_s) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, branch flushes, EX forwarding and
// sequencing of the multi-cycle FP divide/sqrt unit with timeout abort.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] Rs1E,
  input  logic [REG_IDX_W-1:0] Rs2E,
  input  logic [REG_IDX_W-1:0] RdE,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic                 ResultSrcE,
  input  logic                 FpOpE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 floatingWriteM,
  input  logic                 floatingWriteW,
  input  logic                 PCSrcE,
  input  logic                 McOpE,
  input  logic                 mc_done,
  output logic                 mc_start,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 mc_busy,
  output logic                 mc_error,
  output logic [WIDTH-1:0]     stall_cycles
);

  localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stall_q, stall_d;

  logic       lw_stall_s;
  logic       start_s;
  logic       fsm_hold_s;
  logic       abort_flush_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  hazard_sequencer_forward_unit u_fwd_a (
    .rs_i(Rs1E), .fp_op_i(FpOpE),
    .rd_m_i(RdM), .reg_write_m_i(RegWriteM), .fwrite_m_i(floatingWriteM),
    .rd_w_i(RdW), .reg_write_w_i(RegWriteW), .fwrite_w_i(floatingWriteW),
    .fwd_o(fwd_a_s)
  );

  hazard_sequencer_forward_unit u_fwd_b (
    .rs_i(Rs2E), .fp_op_i(FpOpE),
    .rd_m_i(RdM), .reg_write_m_i(RegWriteM), .fwrite_m_i(floatingWriteM),
    .rd_w_i(RdW), .reg_write_w_i(RegWriteW), .fwrite_w_i(floatingWriteW),
    .fwd_o(fwd_b_s)
  );

  // Multi-cycle FSM next state; mc_done beats a simultaneous timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    abort_d       = abort_q;
    err_d         = err_q;
    start_s       = 1'b0;
    fsm_hold_s    = 1'b0;
    abort_flush_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (McOpE) begin
          start_s    = 1'b1;
          fsm_hold_s = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          abort_d    = 1'b0;
          state_d    = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        fsm_hold_s = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (mc_done) begin
          abort_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(MC_TIMEOUT - 1)) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        abort_flush_s = abort_q;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign lw_stall_s = ResultSrcE && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

  // Pipeline controls; FSM holds mask load-use and branch effects.
  always_comb begin
    mc_start  = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = rst;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (fsm_hold_s) begin
      mc_start  = start_s;
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      FlushM    = 1'b1;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end else begin
      StallF    = lw_stall_s;
      StallD    = lw_stall_s;
      FlushD    = PCSrcE;
      FlushE    = lw_stall_s || PCSrcE;
      FlushM    = abort_flush_s;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_comb begin
    stall_d = stall_q;
    if (StallF && (stall_q != {WIDTH{1'b1}})) begin
      stall_d = stall_q + WIDTH'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State, timeout counter, sticky error and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign mc_busy      = (state_q != ST_IDLE);
  assign mc_error     = err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed test-plan cases followed by
// randomized traffic, checked against a behavioural model of the pipeline rules.
module tb_hazard_sequencer;

  localparam int WIDTH      = 8;
  localparam int MC_TIMEOUT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE, FpOpE, RegWriteM, RegWriteW, floatingWriteM, floatingWriteW;
  logic       PCSrcE, McOpE, mc_done;
  logic       mc_start, StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mc_busy, mc_error;
  logic [WIDTH-1:0] stall_cycles;

  hazard_sequencer #(.WIDTH(WIDTH), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .FpOpE(FpOpE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .floatingWriteM(floatingWriteM), .floatingWriteW(floatingWriteW),
    .PCSrcE(PCSrcE), .McOpE(McOpE), .mc_done(mc_done),
    .mc_start(mc_start), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mc_busy(mc_busy), .mc_error(mc_error), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [7:0]       ctrl;    // mc_start, StallF/D/E, FlushD/E/M/W
    logic [3:0]       fwd;     // ForwardAE, ForwardBE
    logic [1:0]       status;  // mc_busy, mc_error
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  // Reference model: an operation is either not in flight, running for
  // m_busy_n cycles so far, or in its single completion cycle.
  bit m_running;
  bit m_finishing;
  bit m_aborted;
  bit m_err;
  int m_busy_n;
  int m_stalls;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    bit mem_ok;
    bit wb_ok;
    mem_ok = RegWriteM && (RdM == rs) && (floatingWriteM == FpOpE) && (floatingWriteM || RdM != 5'd0);
    wb_ok  = RegWriteW && (RdW == rs) && (floatingWriteW == FpOpE) && (floatingWriteW || RdW != 5'd0);
    if (mem_ok) return 2'b10;
    if (wb_ok)  return 2'b01;
    return 2'b00;
  endfunction

  task automatic zero_inputs();
    rst = 1'b0;
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    ResultSrcE = 1'b0; FpOpE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    floatingWriteM = 1'b0; floatingWriteW = 1'b0;
    PCSrcE = 1'b0; McOpE = 1'b0; mc_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then
  // advance the model across the coming clock edge.
  task automatic commit();
    exp_t e;
    bit   lw, start, hold, sf, se, fd, fe, fm;
    lw    = ResultSrcE && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    start = !m_running && !m_finishing && McOpE;
    hold  = m_running || start;
    if (rst) begin
      sf = 1'b0; se = 1'b0; fd = 1'b1; fe = 1'b1; fm = 1'b1;
    end else if (hold) begin
      sf = 1'b1; se = 1'b1; fd = 1'b0; fe = 1'b0; fm = 1'b1;
    end else begin
      sf = lw; se = 1'b0; fd = PCSrcE; fe = lw || PCSrcE; fm = m_finishing && m_aborted;
    end
    e.ctrl   = {start && !rst, sf, sf, se, fd, fe, fm, rst};
    e.fwd    = rst ? 4'b0000 : {fwd_sel(Rs1E), fwd_sel(Rs2E)};
    e.status = {m_running || m_finishing, m_err};
    e.cnt    = WIDTH'(m_stalls);
    exp_q.push_back(e);

    if (rst) begin
      m_running = 1'b0; m_finishing = 1'b0; m_aborted = 1'b0; m_err = 1'b0;
      m_busy_n = 0; m_stalls = 0;
    end else begin
      if (sf && m_stalls < (1 << WIDTH) - 1) m_stalls++;
      if (m_finishing) begin
        m_finishing = 1'b0;
      end else if (m_running) begin
        m_busy_n++;
        if (mc_done) begin
          m_running = 1'b0; m_finishing = 1'b1; m_aborted = 1'b0;
        end else if (m_busy_n == MC_TIMEOUT) begin
          m_running = 1'b0; m_finishing = 1'b1; m_aborted = 1'b1; m_err = 1'b1;
        end
      end else if (McOpE) begin
        m_running = 1'b1; m_busy_n = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("ctrl", 32'({mc_start, StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW}), 32'(got.ctrl));
      check("forward", 32'({ForwardAE, ForwardBE}), 32'(got.fwd));
      check("status", 32'({mc_busy, mc_error}), 32'(got.status));
      check("stall_cycles", 32'(stall_cycles), 32'(got.cnt));
    end
  end

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    m_running = 1'b0; m_finishing = 1'b0; m_aborted = 1'b0; m_err = 1'b0;
    m_busy_n = 0; m_stalls = 0;
    zero_inputs();
    rst = 1'b1;
    tick(); zero_inputs(); rst = 1'b1; commit();
    tick(); zero_inputs(); commit();

    // Forwarding cases
    tick(); zero_inputs(); RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; commit();
    tick(); zero_inputs(); RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; commit();
    tick(); zero_inputs(); RegWriteM = 1'b1; RdM = 5'd0; Rs1E = 5'd0; commit();
    tick(); zero_inputs(); RegWriteM = 1'b1; floatingWriteM = 1'b1; FpOpE = 1'b1; commit();
    tick(); zero_inputs(); RegWriteW = 1'b1; floatingWriteW = 1'b1; RdW = 5'd7; Rs2E = 5'd7; commit();
    tick(); zero_inputs(); RegWriteW = 1'b1; RdW = 5'd9; Rs2E = 5'd9; Rs1E = 5'd9; commit();

    // Load-use, then load-use under a taken branch
    tick(); zero_inputs(); ResultSrcE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; commit();
    tick(); zero_inputs(); commit();
    tick(); zero_inputs(); ResultSrcE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; PCSrcE = 1'b1; commit();

    // Multi-cycle op completing at t+5, McOpE in DONE ignored, back-to-back restart
    tick(); zero_inputs(); McOpE = 1'b1; commit();
    for (int i = 1; i <= 5; i++) begin
      tick(); zero_inputs(); mc_done = (i == 5); commit();
    end
    tick(); zero_inputs(); McOpE = 1'b1; commit();
    tick(); zero_inputs(); McOpE = 1'b1; commit();
    // Second op runs into the timeout
    for (int i = 1; i <= MC_TIMEOUT + 2; i++) begin
      tick(); zero_inputs(); commit();
    end
    // Done coinciding with the timeout cycle: no abort
    tick(); zero_inputs(); McOpE = 1'b1; commit();
    for (int i = 1; i <= MC_TIMEOUT + 2; i++) begin
      tick(); zero_inputs(); mc_done = (i == MC_TIMEOUT); commit();
    end
    // Reset in the second BUSY cycle
    tick(); zero_inputs(); McOpE = 1'b1; commit();
    tick(); zero_inputs(); commit();
    tick(); zero_inputs(); rst = 1'b1; commit();
    tick(); zero_inputs(); commit();
    tick(); zero_inputs(); commit();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      Rs1D = rnd_reg(); Rs2D = rnd_reg(); Rs1E = rnd_reg(); Rs2E = rnd_reg();
      RdE = rnd_reg(); RdM = rnd_reg(); RdW = rnd_reg();
      ResultSrcE = ($urandom_range(0, 2) == 0);
      FpOpE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      floatingWriteM = 1'($urandom_range(0, 1));
      floatingWriteW = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0);
      McOpE = ($urandom_range(0, 3) == 0);
      mc_done = ($urandom_range(0, 4) == 0);
      commit();
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
